// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU and its instruction sequencer:
// packed instruction layout and sequencer state encodings.
package cpu_pkg;

    localparam int IW = 12;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 6;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 3;
    localparam int RS2_MSB = 2;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the instruction sequencer: DEPTH x IW,
// synchronous write, asynchronous (combinational) read. No reset: contents survive rst_n.
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];

    // Write port: one slot per edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: replays a stored program of packed ALU instructions into
// the CPU core, one issue pulse per instruction, advancing on the core's cmd_done.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = cpu_pkg::IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          run,
    input  logic [AW:0]   prog_len,
    input  logic          abort,
    input  logic          cmd_done,
    output logic          start_cmd,
    output logic [2:0]    op_out,
    output logic [2:0]    rd_out,
    output logic [2:0]    rs1_out,
    output logic [2:0]    rs2_out,
    output logic          busy,
    output logic          prog_done,
    output logic          aborted,
    output logic [AW-1:0] pc
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          abort_pend_q, abort_pend_d;
    logic          aborted_q, aborted_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic [IW-1:0] instr_q, instr_d;

    logic          mem_we;
    logic [IW-1:0] mem_rdata;
    logic [AW:0]   len_clamped;
    logic          last_instr;
    logic          abort_eff;

    // Loads are only accepted while no program is in flight.
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mem_we      = load_we && !busy;
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_instr  = ({1'b0, pc_q} == (len_q - 1'b1));

    // Read address follows the next pc so fields are registered on ISSUE entry.
    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_d),
        .rdata_o (mem_rdata)
    );

    // State and output registers; memory is deliberately outside this reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            len_q        <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            len_q        <= len_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            start_q      <= start_d;
            done_q       <= done_d;
            instr_q      <= instr_d;
        end
    end

    // Next-state logic; an abort arriving alongside cmd_done still ends the run.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        abort_eff    = abort_pend_q || abort;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    aborted_d = 1'b0;
                    if (len_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = '0;
                        len_d   = len_clamped;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (cmd_done) begin
                    if (abort_eff || last_instr) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                aborted_d    = abort_pend_q;
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output pulses and instruction fields; a same-cycle load to the fetched slot is forwarded.
    always_comb begin
        start_d = (state_d == S_ISSUE);
        done_d  = (state_d == S_DONE);
        instr_d = instr_q;
        if (state_d == S_ISSUE) begin
            if (mem_we && (load_addr == pc_d)) begin
                instr_d = load_data;
            end else begin
                instr_d = mem_rdata;
            end
        end
    end

    assign start_cmd = start_q;
    assign prog_done = done_q;
    assign aborted   = aborted_q;
    assign pc        = pc_q;
    assign op_out    = instr_q[OP_MSB:OP_LSB];
    assign rd_out    = instr_q[RD_MSB:RD_LSB];
    assign rs1_out   = instr_q[RS1_MSB:RS1_LSB];
    assign rs2_out   = instr_q[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a transaction-level model of the sequencer plus a simple
// core responder, compared every cycle, with directed scenarios and literal spot checks.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        run;
    logic [4:0]  prog_len;
    logic        abort;
    logic        cmd_done;
    logic        start_cmd;
    logic [2:0]  op_out, rd_out, rs1_out, rs2_out;
    logic        busy, prog_done, aborted;
    logic [3:0]  pc;

    logic core_done = 1'b0;
    logic spur_done = 1'b0;
    int   core_cnt   = 0;
    int   core_delay = 2;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    // Model of expected outputs
    bit        model_live = 0;
    bit        e_start, e_busy, e_done, e_aborted;
    int        e_pc;
    bit [11:0] e_instr;
    int        m_len;
    bit        m_abortp;
    bit [11:0] m_mem [16];

    // Issue log
    int        iss_n = 0;
    int        iss_cyc [256];
    bit [11:0] iss_fld [256];
    int        done_cyc = 0;

    assign cmd_done = core_done | spur_done;

    instr_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .run       (run),
        .prog_len  (prog_len),
        .abort     (abort),
        .cmd_done  (cmd_done),
        .start_cmd (start_cmd),
        .op_out    (op_out),
        .rd_out    (rd_out),
        .rs1_out   (rs1_out),
        .rs2_out   (rs2_out),
        .busy      (busy),
        .prog_done (prog_done),
        .aborted   (aborted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Core responder: cmd_done one cycle long, core_delay cycles after start_cmd.
    always @(posedge clk) begin
        #2;
        core_done = 1'b0;
        if (!rst_n) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) core_done = 1'b1;
            end
            if (start_cmd) core_cnt = core_delay;
        end
    end

    // Behavioural model: decides what the sequencer shows after each edge.
    always @(posedge clk) begin
        bit was_done, was_issue, was_wait, do_issue;
        int ln;
        if (!rst_n) begin
            e_start = 0; e_busy = 0; e_done = 0; e_aborted = 0;
            e_pc = 0; e_instr = '0; m_len = 0; m_abortp = 0;
            model_live = 1;
        end else if (model_live) begin
            was_done  = e_done;
            was_issue = e_start;
            was_wait  = e_busy && !e_start;
            do_issue  = 0;
            if (!e_busy && load_we) m_mem[load_addr] = load_data;
            e_start = 0;
            e_done  = 0;
            if (was_done) begin
                e_aborted = m_abortp;
                m_abortp  = 0;
            end else if (was_issue) begin
                if (abort) m_abortp = 1;
            end else if (was_wait) begin
                if (abort) m_abortp = 1;
                if (cmd_done) begin
                    if (m_abortp || e_pc == m_len - 1) begin
                        e_busy = 0;
                        e_done = 1;
                    end else begin
                        e_pc = (e_pc + 1) % 16;
                        do_issue = 1;
                    end
                end
            end else if (run) begin
                ln = (prog_len > 16) ? 16 : int'(prog_len);
                e_aborted = 0;
                if (ln == 0) begin
                    e_done = 1;
                end else begin
                    e_pc = 0;
                    m_len = ln;
                    do_issue = 1;
                end
            end
            if (do_issue) begin
                e_start = 1;
                e_busy  = 1;
                e_instr = m_mem[e_pc];
            end
        end
    end

    task automatic cmp(input string nm, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, plus issue/done logging.
    always @(negedge clk) begin
        if (model_live && rst_n) begin
            cmp("start_cmd", start_cmd, e_start);
            cmp("busy", busy, e_busy);
            cmp("prog_done", prog_done, e_done);
            cmp("aborted", aborted, e_aborted);
            cmp("pc", pc, e_pc);
            cmp("fields", {op_out, rd_out, rs1_out, rs2_out}, e_instr);
        end
        if (start_cmd && iss_n < 256) begin
            iss_cyc[iss_n] = cyc;
            iss_fld[iss_n] = {op_out, rd_out, rs1_out, rs2_out};
            iss_n++;
        end
        if (prog_done) done_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input bit [11:0] d);
        load_we = 1'b1; load_addr = 4'(a); load_data = d;
        step();
        load_we = 1'b0;
    endtask

    task automatic start(input int len);
        run = 1'b1; prog_len = 5'(len);
        step();
        run = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (prog_done) seen = 1;
        end
        ncmp++;
        if (!seen) begin
            nfail++;
            $display("FAIL %s prog_done timeout got=0 expected=1", nm);
        end
        step();
    endtask

    task automatic wait_issue(input int target, input int maxc, input string nm);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (iss_n >= target) seen = 1;
        end
        ncmp++;
        if (!seen) begin
            nfail++;
            $display("FAIL %s issue timeout got=%0d expected=%0d", nm, iss_n, target);
        end
    endtask

    initial begin
        int base;
        rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; prog_len = '0; abort = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        cmp("rst_start", start_cmd, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_pc", pc, 0);
        cmp("rst_fields", {op_out, rd_out, rs1_out, rs2_out}, 0);

        // 1: three-instruction program
        load(0, 12'h053);   // ADD r1 = r2 + r3
        load(1, 12'h30A);   // op1 r4 = r1 , r2
        load(2, 12'h561);   // op2 r5 = r4 , r1
        for (int i = 3; i < 16; i++) load(i, 12'(i * 12'h111));
        base = iss_n;
        start(3);
        wait_done(40, "t1");
        cmp("t1_issues", iss_n - base, 3);
        cmp("t1_gap0", iss_cyc[base+1] - iss_cyc[base], 3);
        cmp("t1_gap1", iss_cyc[base+2] - iss_cyc[base+1], 3);
        cmp("t1_done_lat", done_cyc - iss_cyc[base+2], 3);
        cmp("t1_fld0", iss_fld[base], 12'h053);
        cmp("t1_fld1", iss_fld[base+1], 12'h30A);
        cmp("t1_fld2", iss_fld[base+2], 12'h561);
        cmp("t1_pc", pc, 2);

        // 2: zero-length run
        base = iss_n;
        start(0);
        cmp("t2_done", prog_done, 1);
        cmp("t2_busy", busy, 0);
        step();
        cmp("t2_issues", iss_n - base, 0);
        cmp("t2_done_clr", prog_done, 0);

        // 3: over-long length clamps to 16
        base = iss_n;
        start(20);
        wait_done(120, "t3");
        cmp("t3_issues", iss_n - base, 16);
        cmp("t3_pc", pc, 15);

        // 4: abort during WAIT of instruction 1 of 4, its cmd_done delayed
        base = iss_n;
        start(4);
        wait_issue(base + 1, 20, "t4_i0");
        core_delay = 5;
        wait_issue(base + 2, 20, "t4_i1");
        core_delay = 2;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(40, "t4");
        cmp("t4_issues", iss_n - base, 2);
        cmp("t4_done_lat", done_cyc - iss_cyc[base+1], 6);
        cmp("t4_aborted", aborted, 1);

        // 5: load while busy is dropped; spurious cmd_done in IDLE ignored
        start(1);
        cmp("t5_abort_clr", aborted, 0);
        load(0, 12'hFFF);
        wait_done(20, "t5a");
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        cmp("t5_spur_busy", busy, 0);
        cmp("t5_spur_start", start_cmd, 0);
        cmp("t5_spur_pc", pc, 0);
        start(1);
        cmp("t5_orig_op", {op_out, rd_out, rs1_out, rs2_out}, 12'h053);
        wait_done(20, "t5b");
        // load and run in the same cycle: new slot-0 contents are issued
        load_we = 1'b1; load_addr = 4'd0; load_data = 12'hABC;
        run = 1'b1; prog_len = 5'd1;
        step();
        load_we = 1'b0; run = 1'b0;
        cmp("t5_fwd", {op_out, rd_out, rs1_out, rs2_out}, 12'hABC);
        wait_done(20, "t5c");

        // 6: reset mid-program, then restart
        base = iss_n;
        start(4);
        wait_issue(base + 1, 20, "t6_i0");
        step();
        cmp("t6_wait_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cmp("t6_rst_start", start_cmd, 0);
        cmp("t6_rst_busy", busy, 0);
        cmp("t6_rst_pc", pc, 0);
        cmp("t6_rst_fields", {op_out, rd_out, rs1_out, rs2_out}, 0);
        start(2);
        cmp("t6_restart_start", start_cmd, 1);
        cmp("t6_restart_pc", pc, 0);
        cmp("t6_restart_fld", {op_out, rd_out, rs1_out, rs2_out}, 12'hABC);
        wait_done(20, "t6");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
